// File: rtl/cast_fifo_arbiter_if.sv
// Read-side link between the show-ahead receive FIFOs, the round-robin
// scheduler and the single downstream consumer.
interface cast_fifo_arbiter_if #(
  parameter int width     = 8,
  parameter int num_ports = 4
);
  localparam int src_w = (num_ports > 1) ? $clog2(num_ports) : 1;

  logic [num_ports-1:0]       empty_i;
  logic [num_ports*width-1:0] data_i;
  logic [num_ports-1:0]       read_o;
  logic                       valid_o;
  logic                       ready_i;
  logic [width-1:0]           data_o;
  logic [src_w-1:0]           src_o;

  modport master (
    input  empty_i, data_i, ready_i,
    output read_o, valid_o, data_o, src_o
  );

  modport slave (
    output empty_i, data_i, ready_i,
    input  read_o, valid_o, data_o, src_o
  );
endinterface

// File: rtl/cast_fifo_arbiter.sv
// Round-robin burst-limited scheduler draining show-ahead FIFOs onto one link.
// Pops are combinational; the popped word and its source are registered.
module cast_fifo_arbiter #(
  parameter int width     = 8,
  parameter int num_ports = 4,
  parameter int burst_max = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  cast_fifo_arbiter_if.master bus
);
  localparam int            SW   = $clog2(num_ports);
  localparam logic [SW-1:0] LAST = SW'(num_ports - 1);
  localparam logic [7:0]    BMAX = 8'(burst_max);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [SW-1:0]     grant;
  logic [SW-1:0]     ptr;
  logic [7:0]        cnt;

  logic              vld_p1;
  logic [width-1:0]  data_p1;
  logic [SW-1:0]     src_p1;

  logic [width-1:0]     head [num_ports];
  logic                 ld;
  logic                 pop;
  logic                 stay;
  logic [SW-1:0]        pop_k;
  logic [num_ports-1:0] rd;

  function automatic logic [SW-1:0] nxt(input logic [SW-1:0] idx);
    return (idx == LAST) ? '0 : idx + 1'b1;
  endfunction

  // First non-empty port at or after start, wrapping through every port.
  function automatic logic [SW-1:0] pick(input logic [SW-1:0]        start,
                                         input logic [num_ports-1:0] emp);
    logic [SW-1:0] idx;
    logic          found;
    idx   = start;
    found = 1'b0;
    pick  = start;
    for (int i = 0; i < num_ports; i++) begin
      if (!found && !emp[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = nxt(idx);
    end
  endfunction

  for (genvar k = 0; k < num_ports; k++) begin : g_head
    assign head[k] = bus.data_i[k*width +: width];
  end

  // Stage p0: select the port to pop this cycle
  always_comb begin
    ld    = ~vld_p1 | bus.ready_i;
    pop   = 1'b0;
    stay  = 1'b0;
    pop_k = '0;
    rd    = '0;
    if (rstn_i && ld && !(&bus.empty_i)) begin
      pop = 1'b1;
      if (state == GRANT && !bus.empty_i[grant] && cnt < BMAX) begin
        stay  = 1'b1;
        pop_k = grant;
      end else if (state == GRANT) begin
        pop_k = pick(nxt(grant), bus.empty_i);
      end else begin
        pop_k = pick(ptr, bus.empty_i);
      end
      rd[pop_k] = 1'b1;
    end
  end

  assign bus.read_o = rd;

  // Stage p1: registered output word, source and arbitration state
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      cnt     <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
    end else if (ld) begin
      if (pop) begin
        vld_p1  <= 1'b1;
        data_p1 <= head[pop_k];
        src_p1  <= pop_k;
        grant   <= pop_k;
        cnt     <= stay ? cnt + 8'd1 : 8'd1;
        state   <= GRANT;
      end else begin
        vld_p1 <= 1'b0;
        if (state == GRANT) begin
          ptr   <= nxt(grant);
          state <= IDLE;
        end
      end
    end
  end

  assign bus.valid_o = vld_p1;
  assign bus.data_o  = data_p1;
  assign bus.src_o   = src_p1;
endmodule

// File: doc/cast_fifo_arbiter.md
# cast_fifo_arbiter

Round-robin read-side scheduler that drains up to `num_ports` show-ahead `fifo_inf` receive FIFOs onto one shared output link. It issues single-cycle `read` pops to the FIFOs and registers the popped word with its source index. It limits each grant to a bounded burst so that one busy FIFO cannot starve the others. It sits between the per-direction cast receive FIFOs and the single downstream consumer (local injection / ejection port).

## Interface
- `width`, 8, data word width; matches `fifo_inf` `width`
- `num_ports`, 4, number of FIFOs arbitrated (2..16)
- `burst_max`, 4, max consecutive words popped from one FIFO per grant (1..255)

- `clk_i`  in  1  clock; all logic on rising edge
- `rstn_i`  in  1  reset; one clock, synchronous, active-low
- `empty_i`  in  num_ports  `empty_o` of each FIFO
- `data_i`  in  num_ports*width  head word of each FIFO; port k occupies bits [k*width +: width]
- `read_o`  out  num_ports  pop strobe per FIFO; at most one bit high
- `valid_o`  out  1  `data_o`/`src_o` hold a word
- `ready_i`  in  1  consumer accepts the word this cycle
- `data_o`  out  width  registered output word
- `src_o`  out  $clog2(num_ports)  index of the FIFO that supplied `data_o`

## Operation
- FIFOs are show-ahead: `data_i[k]` is valid whenever `empty_i[k]`=0. A pop on edge t (`read_o[k]`=1) advances the head.
- Load enable: `ld` = ~`valid_o` | `ready_i`.
- State: `state` ∈ {IDLE, GRANT}, `grant` (index), `cnt` (burst count, 8 b), `ptr` (next search start).
- Search function: `pick(start)` returns the first k with `empty_i[k]`=0, scanning start, start+1, … modulo `num_ports`, wrapping through all ports.
- IDLE: if `ld` and any FIFO non-empty:
  - k = `pick(ptr)`
  - `read_o[k]`=1, load `data_o`←`data_i[k]`, `src_o`←k, `valid_o`←1
  - `grant`←k, `cnt`←1, go GRANT
- GRANT, when `ld`:
  - If `empty_i[grant]`=0 and `cnt` < `burst_max`: pop `grant`, `cnt`++.
  - Otherwise rotate: k = `pick(grant+1)`. Pop k, `grant`←k, `cnt`←1. This includes k = `grant` when it is the only non-empty FIFO, so arbitration is work-conserving.
  - If all FIFOs are empty: no pop, `valid_o`←0 (when `ready_i`), `ptr`←`grant`+1 mod `num_ports`, go IDLE.
- When `ld`=0: `read_o`=0; `data_o`, `src_o`, `valid_o`, `cnt`, `grant` all hold.
- `read_o` is combinational from state and inputs. It is never asserted for a port with `empty_i`=1 and never when `ld`=0.
- `valid_o` falls only on a transfer (`valid_o` & `ready_i`) with no replacement pop.

## Timing
- Reset values (while `rstn_i`=0 at an edge, and after):
  - `valid_o`=0, `data_o`=0, `src_o`=0
  - `state`=IDLE, `ptr`=0, `grant`=0, `cnt`=0
- `read_o`=0 during any cycle in which `rstn_i`=0.
- Latency: a word at a FIFO head in cycle t with `ld`=1 and selected appears on `data_o` with `valid_o`=1 in cycle t+1.
- Throughput: 1 word/cycle with `ready_i` held high. A grant rotation or a burst-limit switch costs no bubble.
- Backpressure: `valid_o`=1, `ready_i`=0 ⇒ outputs stable, no pops.
- Simultaneous `ready_i` and new pop: old word transfers and new word loads on the same edge.
- Grant FIFO going empty mid-burst: rotation happens in that same cycle.
- Reset mid-operation: a word held in `data_o` is dropped; any word already popped is lost. The upstream FIFOs are reset by the same domain.
- `ptr` and `grant` wrap from `num_ports`-1 to 0.

## Test plan
- Reset: hold `rstn_i`=0 for 3 cycles with all FIFOs non-empty. Required: `valid_o`=0, `read_o`=0, `data_o`=0. On the first cycle after release, `read_o`=4'b0001.
- Single port: port 2 holds 1..10, others empty, `ready_i`=1. Required: `data_o` 1..10 on 10 consecutive cycles, `src_o`=2 throughout, no bubbles (burst limit re-grants the same port), then `valid_o`=0.
- Fairness: all 4 ports hold 8 words each (port k words k*16+i), `burst_max`=4, `ready_i`=1. Required: `src_o` sequence 0×4, 1×4, 2×4, 3×4, 0×4, 1×4, 2×4, 3×4, for 32 back-to-back words.
- Backpressure: stream from port 1 with `ready_i` toggled 1,0,0,1,0,1. Required: `read_o` low in every `ready_i`=0 cycle, `data_o` stable across stalls, no word lost or duplicated.
- Early rotation: port 0 holds 2 words, port 3 holds 3 words, `burst_max`=4. Required: `src_o` = 0,0,3,3,3, with no idle cycle at the switch.
- Reset mid-burst: assert `rstn_i`=0 for 1 cycle while granting port 1 with `cnt`=2. Required: `valid_o`=0 next cycle, then arbitration restarts from `ptr`=0.
